// File: rtl/reg_file_wr_demux.sv
// Architectural register file: one-hot write demux into 2^ADDR_W registers,
// two combinational read ports with optional same-cycle write forwarding.
module reg_file_wr_demux #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [15:0]       wr_cnt,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [DATA_W-1:0] rd_data_a,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [DATA_W-1:0] rd_data_b
);

    localparam int NREG = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   wr_sel;

    always_comb begin
        wr_sel = '0;
        if (wr_en) wr_sel[wr_addr] = 1'b1;
    end

    // Entry 0 is reset and never loaded, so it stays zero without a special case.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 1; i < NREG; i++) begin
                if (wr_sel[i]) regs[i] <= wr_data;
            end
        end
    end

    // A write to r0 still counts as committed even though storage is untouched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ack <= 1'b0;
            wr_cnt <= '0;
        end else begin
            wr_ack <= wr_en;
            if (wr_en && (wr_cnt != 16'hFFFF)) wr_cnt <= wr_cnt + 16'd1;
        end
    end

    always_comb begin
        rd_data_a = regs[rd_addr_a];
        if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
        if (rd_addr_a == '0) rd_data_a = '0;
    end

    always_comb begin
        rd_data_b = regs[rd_addr_b];
        if ((BYPASS != 0) && wr_en && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
        if (rd_addr_b == '0) rd_data_b = '0;
    end

endmodule

// File: tb/tb_reg_file_wr_demux.sv
// Bench for reg_file_wr_demux: a forwarding and a non-forwarding instance share
// stimulus; commit acks/counts are checked against a queue of expected counts.
module tb_reg_file_wr_demux;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int N  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
    logic [DW-1:0] wr_data;
    logic          ack1, ack0;
    logic [15:0]   cnt1, cnt0;
    logic [DW-1:0] ra1, rb1, ra0, rb0;

    always #5 clk = ~clk;

    reg_file_wr_demux #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(ack1), .wr_cnt(cnt1),
        .rd_addr_a(rd_addr_a), .rd_data_a(ra1), .rd_addr_b(rd_addr_b), .rd_data_b(rb1)
    );

    reg_file_wr_demux #(.DATA_W(DW), .ADDR_W(AW), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_ack(ack0), .wr_cnt(cnt0),
        .rd_addr_a(rd_addr_a), .rd_data_a(ra0), .rd_addr_b(rd_addr_b), .rd_data_b(rb0)
    );

    int unsigned vecs = 0;
    int unsigned errs = 0;
    logic [DW-1:0] mdl [N];
    int unsigned   mcnt = 0;
    logic [15:0]   exp_q [$];

    typedef struct {
        logic          en;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] a;
        logic [AW-1:0] b;
        logic [DW-1:0] ea;
        logic [DW-1:0] eb;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] stored(input logic [AW-1:0] a);
        return (a == 0) ? '0 : mdl[a];
    endfunction

    function automatic logic [DW-1:0] fwd(input logic en, input logic [AW-1:0] wa,
                                          input logic [DW-1:0] wd, input logic [AW-1:0] a);
        if (a == 0) return '0;
        if (en && (wa == a)) return wd;
        return mdl[a];
    endfunction

    // Drive one cycle at the falling edge, check reads before the next rising edge.
    task automatic cycle(input logic en, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic [AW-1:0] a, input logic [AW-1:0] b,
                         input logic [DW-1:0] ea, input logic [DW-1:0] eb);
        @(negedge clk);
        wr_en = en; wr_addr = wa; wr_data = wd; rd_addr_a = a; rd_addr_b = b;
        #1;
        check("byp_rd_a", ra1, ea);
        check("byp_rd_b", rb1, eb);
        check("nob_rd_a", ra0, stored(a));
        check("nob_rd_b", rb0, stored(b));
        if (en) begin
            if (mcnt < 32'hFFFF) mcnt++;
            exp_q.push_back(mcnt[15:0]);
            if (wa != 0) mdl[wa] = wd;
        end
    endtask

    always @(posedge clk) begin : monitor
        logic [15:0] e;
        #2;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("ack_byp", ack1, 1);
            check("ack_nob", ack0, 1);
            check("cnt_byp", cnt1, e);
            check("cnt_nob", cnt0, e);
        end else begin
            check("ack_idle_byp", ack1, 0);
            check("ack_idle_nob", ack0, 0);
        end
    end

    vec_t tbl [9];

    initial begin
        tbl[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[1] = '{1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 32'hDEADBEEF, 32'hDEADBEEF};
        tbl[2] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF};
        tbl[3] = '{1'b0, 5'd0, 32'h0,        5'd0, 5'd0, 32'h0,        32'h0};
        tbl[4] = '{1'b1, 5'd7, 32'h11111111, 5'd7, 5'd3, 32'h11111111, 32'h0};
        tbl[5] = '{1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7, 32'h22222222, 32'h22222222};
        tbl[6] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd5, 32'h22222222, 32'hDEADBEEF};
        tbl[7] = '{1'b1, 5'd3, 32'hA5A5A5A5, 5'd5, 5'd3, 32'hDEADBEEF, 32'hA5A5A5A5};
        tbl[8] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd7, 32'hA5A5A5A5, 32'h22222222};

        for (int i = 0; i < N; i++) mdl[i] = '0;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_addr_a = 5'd5; rd_addr_b = 5'd31;
        #1;
        check("rst_ack", ack1, 0);
        check("rst_cnt", cnt1, 0);
        check("rst_rd_a", ra1, 0);
        check("rst_rd_b", rb0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++)
            cycle(tbl[i].en, tbl[i].wa, tbl[i].wd, tbl[i].a, tbl[i].b, tbl[i].ea, tbl[i].eb);

        // Walking-one write into every register, then read them all back.
        for (int i = 1; i < N; i++)
            cycle(1'b1, AW'(i), 32'h1 << i, AW'(i), 5'd0, 32'h1 << i, 32'h0);
        for (int i = 0; i < N; i++)
            cycle(1'b0, 5'd0, 32'h0, AW'(i), AW'(N - 1 - i),
                  (i == 0) ? 32'h0 : (32'h1 << i), (i == N - 1) ? 32'h0 : (32'h1 << (N - 1 - i)));

        // Asynchronous reset mid-cycle, right after a committed write.
        cycle(1'b1, 5'd9, 32'h99999999, 5'd9, 5'd5, 32'h99999999, 32'h00000020);
        @(negedge clk);
        wr_en = 1'b0;
        #2;
        check("pre_rst_ack", ack1, 1);
        rst = 1'b1;
        #1;
        check("async_rst_ack_byp", ack1, 0);
        check("async_rst_ack_nob", ack0, 0);
        check("async_rst_cnt_byp", cnt1, 0);
        check("async_rst_cnt_nob", cnt0, 0);
        check("async_rst_rd_a", ra1, 0);
        check("async_rst_rd_b", rb1, 0);
        check("async_rst_nob_a", ra0, 0);
        for (int i = 0; i < N; i++) mdl[i] = '0;
        mcnt = 0;

        // Write presented while reset is held across the edge must be dropped.
        @(negedge clk);
        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'hCAFEF00D; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
        @(negedge clk);
        rst = 1'b0; wr_en = 1'b0;
        #1;
        check("rst_wr_r3", ra1, 0);
        check("rst_wr_ack", ack1, 0);
        check("rst_wr_cnt", cnt1, 0);
        cycle(1'b0, 5'd0, 32'h0, 5'd3, 5'd9, 32'h0, 32'h0);

        // Back-to-back writes drive the counter into saturation.
        for (int k = 0; k < 65534 + 3; k++)
            cycle(1'b1, 5'd1, DW'(k), 5'd2, 5'd1, 32'h0, DW'(k));
        cycle(1'b0, 5'd0, 32'h0, 5'd1, 5'd0, 32'(65536), 32'h0);
        check("sat_cnt_byp", cnt1, 16'hFFFF);
        check("sat_cnt_nob", cnt0, 16'hFFFF);
        cycle(1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/reg_file_wr_demux.md
Name: reg_file_wr_demux

Overview:
- Write-side counterpart of the datapath's 2:1 32-bit select logic: a 1-to-N write demultiplexer that steers one 32-bit write-back value into one of 2^ADDR_W architectural registers.
- Also contains the register storage and two combinational read ports.
- Sits between the write-back stage and the decode stage of the CPU datapath.
- Register 0 is hardwired to zero.

Parameters:
- DATA_W, 32, width of each register and of write/read data.
- ADDR_W, 5, register address width; register count = 2^ADDR_W.
- BYPASS, 1, 1 = a same-cycle write is forwarded to read ports; 0 = reads return the stored value only.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- wr_en  input  1  write request this cycle.
- wr_addr  input  ADDR_W  destination register index.
- wr_data  input  DATA_W  value to store.
- wr_ack  output  1  one-cycle pulse: previous cycle's write was committed.
- wr_cnt  output  16  count of committed writes, saturating.
- rd_addr_a  input  ADDR_W  read port A index.
- rd_data_a  output  DATA_W  read port A data, combinational.
- rd_addr_b  input  ADDR_W  read port B index.
- rd_data_b  output  DATA_W  read port B data, combinational.

Behaviour:
- Interface (already decided): one clock; reset is asynchronous and active-high. Clock port is clk, reset port is rst.
- Reset (rst=1, immediate, no clock needed):
  - all registers = 0;
  - wr_ack = 0;
  - wr_cnt = 0.
- Reset mid-operation: any write sampled in the same cycle as rst is discarded. No ack and no count increment for it.
- Write decode: on a rising clk edge with rst=0 and wr_en=1:
  - one-hot decode of wr_addr enables exactly one register;
  - that register loads wr_data;
  - all other registers hold.
- Register 0:
  - writes with wr_addr=0 never change storage; it reads as 0 always;
  - such a write still counts as committed, so wr_ack pulses and wr_cnt increments.
- wr_ack:
  - registered; equals wr_en sampled at the previous edge;
  - latency 1 cycle from the write edge;
  - back-to-back writes give wr_ack held high for the same number of cycles.
- wr_cnt: +1 per committed write; saturates at 16'hFFFF with no wrap.
- Read ports:
  - purely combinational from storage; 0 latency;
  - if rd_addr = 0, output 0 regardless of BYPASS.
- Bypass (BYPASS=1):
  - when wr_en=1, wr_addr == rd_addr, and wr_addr != 0, the read port outputs wr_data in the same cycle;
  - the A and B ports are evaluated independently; both may bypass simultaneously.
- BYPASS=0: reads show the new value only after the write edge.
- Simultaneous read of the same address on A and B: both return identical data.
- Width rules:
  - no sign/zero extension inside the block;
  - out-of-range addresses cannot occur because the register count is exactly 2^ADDR_W.
- Only one write per cycle; no write-write conflict is possible.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle with registers preloaded -> all rd_data = 0, wr_ack = 0, wr_cnt = 0 immediately, before the next clk edge.
- Basic write/read: write 32'hDEADBEEF to r5, then read A=5, B=5 next cycle -> both 32'hDEADBEEF; wr_ack = 1 for exactly one cycle; wr_cnt = 1.
- Decode isolation: write 32'h0000_0001 << i to ri for i = 1..31, then read all registers -> each holds only its own value; r0 reads 0.
- r0 write: write 32'hFFFFFFFF to r0 -> rd_data_a(addr 0) = 0; wr_ack pulses; wr_cnt increments.
- Bypass: BYPASS=1 with r7 = 32'h1111_1111; in the same cycle set wr_en=1, wr_addr=7, wr_data=32'h2222_2222, rd_addr_a=7 -> rd_data_a = 32'h2222_2222 before the edge. With BYPASS=0 -> 32'h1111_1111 before the edge, 32'h2222_2222 after it.
- Reset during write plus saturation:
  - rst high on the same edge as a write to r3 -> r3 = 0, no wr_ack;
  - preload wr_cnt near 16'hFFFE, then do 3 writes -> wr_cnt stays at 16'hFFFF.
